// File: rtl/imem_load_arb.sv
// imem_load_arb: shares a single-port synchronous instruction RAM between CPU fetch and a program loader.
// Optional feature: define IMEM_LOAD_CSUM_EN to add ld_csum, a running XOR of loaded words.
module imem_load_arb #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'hE1A00000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_err,
  output logic              cpu_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  input  logic              ld_start,
  output logic [ADDR_W:0]   ld_count,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_LOAD_CSUM_EN
  ,
  output logic [DATA_W-1:0] ld_csum
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              rvalid_q, err_q;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              grant, fetch_in_range, xfer, enter_load;
  logic [ADDR_W-1:0] fetch_idx;
  logic              unused_addr_bits;

  // Byte offset bits are don't-care: fetches are always word aligned.
  assign unused_addr_bits = ^fetch_addr[1:0];
  assign fetch_in_range   = (fetch_addr[31:ADDR_W+2] == '0);
  assign fetch_idx        = fetch_addr[ADDR_W+1:2];

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    ld_ready  = 1'b0;
    cpu_stall = 1'b1;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ld_addr;
    mem_wdata = ld_data;
    if (reset_n) begin
      case (state_q)
        S_LOAD: begin
          ld_ready = 1'b1;
          if (ld_done && !ld_start) state_d = S_RUN;
        end
        S_RUN: begin
          grant     = fetch_req;
          cpu_stall = !fetch_req;
          ld_ready  = !fetch_req;
          // A fetch granted in the ld_start cycle still owes its response.
          if (ld_start) state_d = grant ? S_DRAIN : S_LOAD;
        end
        S_DRAIN: state_d = S_LOAD;
        default: state_d = S_LOAD;
      endcase
      if (grant && fetch_in_range) begin
        mem_en   = 1'b1;
        mem_addr = fetch_idx;
      end else if (ld_valid && ld_ready) begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
    end
  end

  assign xfer       = ld_valid && ld_ready;
  assign enter_load = (state_q != S_LOAD) && (state_d == S_LOAD);

  always_comb begin
    cnt_d = cnt_q;
    if (enter_load)                  cnt_d = '0;
    else if (xfer && cnt_q != DEPTH) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_LOAD;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= grant;
      err_q    <= grant && !fetch_in_range;
      cnt_q    <= cnt_d;
    end
  end

  assign fetch_rvalid = rvalid_q;
  assign fetch_err    = err_q;
  assign fetch_rdata  = !rvalid_q ? '0 : (err_q ? NOP_WORD : mem_rdata);
  assign ld_count     = cnt_q;

`ifdef IMEM_LOAD_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (enter_load) csum_d = '0;
    else if (xfer)  csum_d = csum_q ^ ld_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign ld_csum = csum_q;
`endif

endmodule

// File: tb/tb_imem_load_arb.sv
// tb_imem_load_arb: randomized self-checking bench for imem_load_arb with a behavioural RAM and reference model.
// Checksum checks are compiled in when IMEM_LOAD_CSUM_EN is defined.
module tb_imem_load_arb;
  localparam int          ADDR_W = 6;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 64;
  localparam logic [31:0] NOP    = 32'hE1A00000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_rvalid, fetch_err, cpu_stall, ld_ready;
  logic [DATA_W-1:0] fetch_rdata;
  logic              ld_valid, ld_done, ld_start;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W:0]   ld_count;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef IMEM_LOAD_CSUM_EN
  logic [DATA_W-1:0] ld_csum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_load_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .cpu_stall(cpu_stall), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done), .ld_start(ld_start), .ld_count(ld_count),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef IMEM_LOAD_CSUM_EN
    , .ld_csum(ld_csum)
`endif
  );

  // Behavioural single-port synchronous RAM attached to the mem_* port.
  logic [31:0] ram [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: operating mode, expected RAM image, counters and the pending fetch response.
  localparam int M_LOAD = 0, M_RUN = 1, M_DRAIN = 2;
  int          mode = M_LOAD;
  logic [31:0] img [DEPTH] = '{default: '0};
  int          m_count = 0;
  logic [31:0] m_csum = '0;
  logic        r_vld = 1'b0, r_err = 1'b0;
  logic [31:0] r_data = '0;
  logic        e_grant, e_ready, e_stall, e_en, e_we, e_inr, e_xfer;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0] e_wdata;

  task automatic idle();
    fetch_req = 0; fetch_addr = '0; ld_valid = 0; ld_addr = '0; ld_data = '0;
    ld_done = 0; ld_start = 0;
  endtask

  task automatic model_eval();
    #1;
    e_inr = ((fetch_addr >> (ADDR_W + 2)) == 0);
    e_grant = 0; e_ready = 0; e_stall = 1; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    if (reset_n) begin
      if (mode == M_LOAD) e_ready = 1;
      else if (mode == M_RUN) begin
        e_ready = !fetch_req; e_stall = !fetch_req; e_grant = fetch_req;
      end
      if (e_grant && e_inr) begin
        e_en = 1; e_addr = ADDR_W'((fetch_addr % (DEPTH * 4)) / 4);
      end else if (e_ready && ld_valid) begin
        e_en = 1; e_we = 1; e_addr = ld_addr; e_wdata = ld_data;
      end
    end
    e_xfer = e_ready && ld_valid;
  endtask

  task automatic tick();
    int prev = mode;
    if (!reset_n) begin
      mode = M_LOAD; m_count = 0; m_csum = '0; r_vld = 0; r_err = 0; r_data = '0;
    end else begin
      r_vld  = e_grant;
      r_err  = e_grant && !e_inr;
      r_data = !e_grant ? 32'h0 : (e_inr ? img[(fetch_addr % (DEPTH * 4)) / 4] : NOP);
      if (e_xfer) begin
        img[ld_addr] = ld_data;
        if (m_count < DEPTH) m_count++;
        m_csum ^= ld_data;
      end
      if (mode == M_LOAD) begin
        if (ld_done && !ld_start) mode = M_RUN;
      end else if (mode == M_RUN) begin
        if (ld_start) mode = e_grant ? M_DRAIN : M_LOAD;
      end else mode = M_LOAD;
      if (mode == M_LOAD && prev != M_LOAD) begin m_count = 0; m_csum = '0; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0; idle(); fetch_req = 1; ld_valid = 1; ld_addr = 5; ld_data = 32'h12345678;
    model_eval();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_cycle_mem_en got %b want 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_cycle_mem_we got %b want 0", mem_we); end
    tick(); tick();
    reset_n = 1; idle();
    model_eval();
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got %b want 1", cpu_stall); end
    checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", fetch_rvalid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", fetch_err); end
    checks++; if (fetch_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", fetch_rdata); end
    checks++; if (ld_count !== 7'd0) begin errors++; $display("FAIL rst_count got %0d want 0", ld_count); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
`ifdef IMEM_LOAD_CSUM_EN
    checks++; if (ld_csum !== 32'h0) begin errors++; $display("FAIL rst_csum got %h want 0", ld_csum); end
`endif
    tick();
  endtask

  task automatic test_load_and_fetch();
    for (int i = 0; i < 4; i++) begin
      idle(); ld_valid = 1; ld_addr = ADDR_W'(i); ld_data = 32'hE3A00001 + i;
      if (i == 3) ld_done = 1;
      model_eval();
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready[%0d] got %b want 1", i, ld_ready); end
      checks++; if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL load_en_we[%0d] got %b want 11", i, {mem_en, mem_we}); end
      checks++; if (mem_addr !== ADDR_W'(i)) begin errors++; $display("FAIL load_addr[%0d] got %0d want %0d", i, mem_addr, i); end
      checks++; if (mem_wdata !== 32'hE3A00001 + i) begin errors++; $display("FAIL load_wdata[%0d] got %h want %h", i, mem_wdata, 32'hE3A00001 + i); end
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load_stall[%0d] got %b want 1", i, cpu_stall); end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) begin fetch_req = 1; fetch_addr = 32'(i * 4); end
      model_eval();
      checks++; if (ld_count !== 7'd4) begin errors++; $display("FAIL run_count got %0d want 4", ld_count); end
      if (i < 4) begin
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL run_stall[%0d] got %b want 0", i, cpu_stall); end
        checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, ADDR_W'(i)}) begin errors++; $display("FAIL fetch_mem[%0d] got %b want %b", i, {mem_en, mem_we, mem_addr}, {2'b10, ADDR_W'(i)}); end
      end
      if (i > 0) begin
        checks++; if ({fetch_rvalid, fetch_err} !== 2'b10) begin errors++; $display("FAIL fetch_vld[%0d] got %b want 10", i, {fetch_rvalid, fetch_err}); end
        checks++; if (fetch_rdata !== 32'hE3A00001 + i - 1) begin errors++; $display("FAIL fetch_data[%0d] got %h want %h", i, fetch_rdata, 32'hE3A00001 + i - 1); end
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    for (int i = 0; i < 4; i++) begin
      idle(); ld_valid = 1; ld_addr = 6'd10; ld_data = 32'hA5A50000 + i;
      fetch_req = (i < 3); fetch_addr = 32'h4;
      model_eval();
      checks++; if (ld_ready !== (i == 3)) begin errors++; $display("FAIL conflict_ready[%0d] got %b want %b", i, ld_ready, i == 3); end
      checks++; if (mem_we !== (i == 3)) begin errors++; $display("FAIL conflict_we[%0d] got %b want %b", i, mem_we, i == 3); end
      checks++; if (fetch_rvalid !== r_vld || fetch_rdata !== r_data) begin errors++; $display("FAIL conflict_resp[%0d] got %b/%h want %b/%h", i, fetch_rvalid, fetch_rdata, r_vld, r_data); end
      tick();
    end
    idle(); ld_done = 1; model_eval(); tick();
    idle(); fetch_req = 1; fetch_addr = 32'h28; model_eval();
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL done_in_run_stall got %b want 0", cpu_stall); end
    tick();
    idle(); model_eval();
    checks++; if (fetch_rdata !== 32'hA5A50003) begin errors++; $display("FAIL conflict_write_data got %h want a5a50003", fetch_rdata); end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [2] = '{32'h100, 32'h80000004};
    for (int i = 0; i < 2; i++) begin
      idle(); fetch_req = 1; fetch_addr = addrs[i]; ld_valid = 1;
      model_eval();
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL oor_mem_en[%0d] got %b want 0", i, mem_en); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL oor_stall[%0d] got %b want 0", i, cpu_stall); end
      tick();
      idle(); model_eval();
      checks++; if ({fetch_rvalid, fetch_err} !== 2'b11) begin errors++; $display("FAIL oor_flags[%0d] got %b want 11", i, {fetch_rvalid, fetch_err}); end
      checks++; if (fetch_rdata !== NOP) begin errors++; $display("FAIL oor_rdata[%0d] got %h want %h", i, fetch_rdata, NOP); end
      tick();
    end
  endtask

  task automatic test_random_run();
    for (int c = 0; c < 300; c++) begin
      idle();
      fetch_req = ($urandom_range(9) < 4);
      if ($urandom_range(7) == 0) fetch_addr = $urandom | 32'h100;
      else fetch_addr = 32'($urandom_range(DEPTH - 1) * 4 + $urandom_range(3));
      ld_valid = ($urandom_range(9) < 6);
      ld_addr = ADDR_W'($urandom_range(DEPTH - 1));
      ld_data = $urandom;
      ld_done = ($urandom_range(15) == 0);
      model_eval();
      checks++; if (ld_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, ld_ready, e_ready); end
      checks++; if (cpu_stall !== e_stall) begin errors++; $display("FAIL rnd_stall c%0d got %b want %b", c, cpu_stall, e_stall); end
      checks++; if ({mem_en, mem_we} !== {e_en, e_we}) begin errors++; $display("FAIL rnd_en_we c%0d got %b want %b", c, {mem_en, mem_we}, {e_en, e_we}); end
      if (e_en) begin
        checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr c%0d got %0d want %0d", c, mem_addr, e_addr); end
      end
      if (e_we) begin
        checks++; if (mem_wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata c%0d got %h want %h", c, mem_wdata, e_wdata); end
      end
      checks++; if ({fetch_rvalid, fetch_err} !== {r_vld, r_err}) begin errors++; $display("FAIL rnd_flags c%0d got %b want %b", c, {fetch_rvalid, fetch_err}, {r_vld, r_err}); end
      checks++; if (fetch_rdata !== r_data) begin errors++; $display("FAIL rnd_rdata c%0d got %h want %h", c, fetch_rdata, r_data); end
      checks++; if (ld_count !== 7'(m_count)) begin errors++; $display("FAIL rnd_count c%0d got %0d want %0d", c, ld_count, m_count); end
`ifdef IMEM_LOAD_CSUM_EN
      checks++; if (ld_csum !== m_csum) begin errors++; $display("FAIL rnd_csum c%0d got %h want %h", c, ld_csum, m_csum); end
`endif
      tick();
    end
    idle(); model_eval();
    checks++; if (ld_count !== 7'd64) begin errors++; $display("FAIL count_saturate got %0d want 64", ld_count); end
    tick();
  endtask

  task automatic test_drain();
    idle(); fetch_req = 1; fetch_addr = 32'h8; model_eval(); tick();
    idle(); fetch_req = 1; fetch_addr = 32'hC; ld_start = 1; model_eval();
    checks++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== r_data) begin errors++; $display("FAIL drain_prev_resp got %b/%h want 1/%h", fetch_rvalid, fetch_rdata, r_data); end
    tick();
    idle(); fetch_req = 1; fetch_addr = 32'h0; ld_valid = 1; model_eval();
    checks++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== img[3]) begin errors++; $display("FAIL drain_resp got %b/%h want 1/%h", fetch_rvalid, fetch_rdata, img[3]); end
    checks++; if ({cpu_stall, ld_ready, mem_en} !== 3'b100) begin errors++; $display("FAIL drain_ctl got %b want 100", {cpu_stall, ld_ready, mem_en}); end
    tick();
    idle(); ld_valid = 1; ld_data = 32'h11; ld_start = 1; model_eval();
    checks++; if ({cpu_stall, ld_ready, fetch_rvalid} !== 3'b110) begin errors++; $display("FAIL reload_ctl got %b want 110", {cpu_stall, ld_ready, fetch_rvalid}); end
    checks++; if (ld_count !== 7'd0) begin errors++; $display("FAIL reload_count got %0d want 0", ld_count); end
    tick();
    idle(); ld_done = 1; ld_start = 1; model_eval();
    checks++; if (ld_count !== 7'd1) begin errors++; $display("FAIL start_in_load_count got %0d want 1", ld_count); end
    tick();
    idle(); fetch_req = 1; model_eval();
    checks++; if ({cpu_stall, mem_en} !== 2'b10) begin errors++; $display("FAIL done_start_stays got %b want 10", {cpu_stall, mem_en}); end
    tick();
    idle(); ld_done = 1; model_eval(); tick();
    idle(); ld_start = 1; model_eval(); tick();
    idle(); fetch_req = 1; model_eval();
    checks++; if ({cpu_stall, ld_ready, mem_en} !== 3'b110) begin errors++; $display("FAIL direct_load_ctl got %b want 110", {cpu_stall, ld_ready, mem_en}); end
    checks++; if (ld_count !== 7'd0) begin errors++; $display("FAIL direct_load_count got %0d want 0", ld_count); end
    tick();
  endtask

`ifdef IMEM_LOAD_CSUM_EN
  task automatic test_csum();
    idle(); ld_valid = 1; ld_data = 32'h0000FFFF; model_eval(); tick();
    idle(); ld_valid = 1; ld_addr = 1; ld_data = 32'hFFFF0000; model_eval();
    checks++; if (ld_csum !== 32'h0000FFFF) begin errors++; $display("FAIL csum_first got %h want 0000ffff", ld_csum); end
    tick();
    idle(); ld_done = 1; model_eval();
    checks++; if (ld_csum !== 32'hFFFFFFFF) begin errors++; $display("FAIL csum_pair got %h want ffffffff", ld_csum); end
    tick();
    idle(); ld_start = 1; model_eval(); tick();
    idle(); model_eval();
    checks++; if (ld_csum !== 32'h0) begin errors++; $display("FAIL csum_clear got %h want 0", ld_csum); end
    tick();
  endtask
`endif

  task automatic test_reset_mid_load();
    for (int i = 0; i < 3; i++) begin
      idle(); ld_valid = 1; ld_addr = ADDR_W'(20 + i); ld_data = $urandom; model_eval(); tick();
    end
    idle(); reset_n = 0; ld_valid = 1; ld_done = 1; model_eval();
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL midrst_cycle got %b want 00", {mem_en, mem_we}); end
    tick();
    reset_n = 1; idle(); fetch_req = 1; model_eval();
    checks++; if ({cpu_stall, fetch_rvalid, fetch_err, mem_en} !== 4'b1000) begin errors++; $display("FAIL midrst_flags got %b want 1000", {cpu_stall, fetch_rvalid, fetch_err, mem_en}); end
    checks++; if (ld_count !== 7'd0 || fetch_rdata !== 32'h0) begin errors++; $display("FAIL midrst_vals got %0d/%h want 0/0", ld_count, fetch_rdata); end
    tick();
    idle(); fetch_req = 1; fetch_addr = 32'h50; model_eval();
    checks++; if ({cpu_stall, mem_en, fetch_rvalid} !== 3'b100) begin errors++; $display("FAIL midrst_no_run got %b want 100", {cpu_stall, mem_en, fetch_rvalid}); end
    tick();
  endtask

  initial begin
    reset_n = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_load_and_fetch();
    test_conflict();
    test_out_of_range();
    test_random_run();
    test_drain();
`ifdef IMEM_LOAD_CSUM_EN
    test_csum();
`endif
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
